// File: rtl/sdlc_sum_arbiter_if.sv
// sdlc_sum_arbiter_if: handshake bundle between two multiplier front ends,
// the shared four-operand SDLC summer and the result consumer.
//
// Signals:
//   req0_valid/req0_ready/req0_pp : requester 0 operands (R1 in low W bits)
//   req1_valid/req1_ready/req1_pp : requester 1 operands
//   res_valid/res_ready           : result handshake
//   res_sum/res_ovf/res_id        : truncated sum, carry-out, source id
//   occupancy                     : number of full pipeline stages
interface sdlc_sum_arbiter_if #(
    parameter int W = 15
);
    logic           req0_valid;
    logic           req0_ready;
    logic [4*W-1:0] req0_pp;
    logic           req1_valid;
    logic           req1_ready;
    logic [4*W-1:0] req1_pp;
    logic           res_valid;
    logic           res_ready;
    logic [W:0]     res_sum;
    logic           res_ovf;
    logic           res_id;
    logic [1:0]     occupancy;

    // arbiter side
    modport slave (
        input  req0_valid,
        input  req0_pp,
        input  req1_valid,
        input  req1_pp,
        input  res_ready,
        output req0_ready,
        output req1_ready,
        output res_valid,
        output res_sum,
        output res_ovf,
        output res_id,
        output occupancy
    );

    // requester / consumer side
    modport master (
        output req0_valid,
        output req0_pp,
        output req1_valid,
        output req1_pp,
        output res_ready,
        input  req0_ready,
        input  req1_ready,
        input  res_valid,
        input  res_sum,
        input  res_ovf,
        input  res_id,
        input  occupancy
    );
endinterface

// File: rtl/sdlc_sum_arbiter.sv
// sdlc_sum_arbiter: round-robin arbiter sharing one 4-row SDLC summer
// between two front ends; two-stage pipeline with result backpressure.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : sdlc_sum_arbiter_if.slave (requests, result, occupancy)
module sdlc_sum_arbiter #(
    parameter int W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    sdlc_sum_arbiter_if.slave bus
);
    // stage enables and grant
    logic           w_s2_adv;
    logic           w_s1_adv;
    logic           w_gnt0;
    logic           w_gnt1;
    logic           w_rdy0;
    logic           w_rdy1;
    logic           w_xfer0;
    logic           w_xfer1;
    logic           w_xfer;
    logic [4*W-1:0] w_pp_in;
    logic           w_id_in;
    logic [W+1:0]   w_full;

    // S1: operand register
    logic           r_s1_valid;
    logic [4*W-1:0] r_s1_pp;
    logic           r_s1_id;

    // S2: output register
    logic           r_s2_valid;
    logic [W:0]     r_s2_sum;
    logic           r_s2_ovf;
    logic           r_s2_id;

    logic           r_last_grant;

    assign w_s2_adv = !r_s2_valid || bus.res_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;

    // r_last_grant==1 means requester 1 won last, so requester 0 wins a tie
    assign w_gnt0 = bus.req0_valid
                 && (!bus.req1_valid || r_last_grant);
    assign w_gnt1 = bus.req1_valid
                 && (!bus.req0_valid || !r_last_grant);

    assign w_rdy0 = w_gnt0 && w_s1_adv;
    assign w_rdy1 = w_gnt1 && w_s1_adv;

    assign bus.req0_ready = w_rdy0;
    assign bus.req1_ready = w_rdy1;

    assign w_xfer0 = bus.req0_valid && w_rdy0;
    assign w_xfer1 = bus.req1_valid && w_rdy1;
    assign w_xfer  = w_xfer0 || w_xfer1;

    assign w_pp_in = w_xfer1 ? bus.req1_pp : bus.req0_pp;
    assign w_id_in = w_xfer1;

    // full-width sum; bit W+1 is the overflow flag
    assign w_full = {2'b00, r_s1_pp[W-1:0]}
                  + {2'b00, r_s1_pp[2*W-1:W]}
                  + {2'b00, r_s1_pp[3*W-1:2*W]}
                  + {2'b00, r_s1_pp[4*W-1:3*W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_pp    <= '0;
            r_s1_id    <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= w_xfer;
            if (w_xfer) begin
                r_s1_pp <= w_pp_in;
                r_s1_id <= w_id_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_sum   <= '0;
            r_s2_ovf   <= 1'b0;
            r_s2_id    <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sum <= w_full[W:0];
                r_s2_ovf <= w_full[W+1];
                r_s2_id  <= r_s1_id;
            end
        end
    end

    // moves only on an actual transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (w_xfer) begin
            r_last_grant <= w_id_in;
        end
    end

    assign bus.res_valid = r_s2_valid;
    assign bus.res_sum   = r_s2_sum;
    assign bus.res_ovf   = r_s2_ovf;
    assign bus.res_id    = r_s2_id;
    assign bus.occupancy = {1'b0, r_s1_valid} + {1'b0, r_s2_valid};
endmodule

// File: tb/tb_sdlc_sum_arbiter.sv
// tb_sdlc_sum_arbiter: directed and random stimulus for sdlc_sum_arbiter,
// checked against an in-order FIFO model with one-cycle minimum residence.
module tb_sdlc_sum_arbiter;
    localparam int W = 15;

    logic clk;
    logic rst_n;

    sdlc_sum_arbiter_if #(.W(W)) bus ();

    sdlc_sum_arbiter #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        int id;
        int sum;
        int ovf;
        int age;
    } ent_t;

    ent_t q[$];
    int   m_last = 1;

    function automatic ent_t mk(input int id, input logic [59:0] pp);
        ent_t e;
        int   s;
        s = int'(pp[14:0]) + int'(pp[29:15])
          + int'(pp[44:30]) + int'(pp[59:45]);
        e.id  = id;
        e.sum = s % 65536;
        e.ovf = s / 65536;
        e.age = 0;
        return e;
    endfunction

    always begin : p_model
        bit          v0, v1, rr, adv, er0, er1, ev, a0, a1, cons;
        logic [59:0] pp0, pp1;
        @(negedge clk);
        if (!rst_n) begin
            q.delete();
            m_last = 1;
        end
        v0  = bus.req0_valid;
        v1  = bus.req1_valid;
        rr  = bus.res_ready;
        // a full pipeline accepts only if the head leaves this edge
        adv = (q.size() < 2) || rr;
        er0 = v0 && (!v1 || m_last == 1) && adv;
        er1 = v1 && (!v0 || m_last == 0) && adv;
        ev  = (q.size() > 0) && (q[0].age >= 1);
        chk("m_ready0", bus.req0_ready, er0);
        chk("m_ready1", bus.req1_ready, er1);
        chk("m_res_valid", bus.res_valid, ev);
        chk("m_occupancy", bus.occupancy, q.size());
        if (ev) begin
            chk("m_res_id", bus.res_id, q[0].id);
            chk("m_res_sum", bus.res_sum, q[0].sum);
            chk("m_res_ovf", bus.res_ovf, q[0].ovf);
        end
        a0   = v0 && er0;
        a1   = v1 && er1;
        cons = ev && rr;
        pp0  = bus.req0_pp;
        pp1  = bus.req1_pp;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_last = 1;
        end else begin
            if (cons) void'(q.pop_front());
            foreach (q[i]) q[i].age++;
            if (a0) begin
                q.push_back(mk(0, pp0));
                m_last = 0;
            end
            if (a1) begin
                q.push_back(mk(1, pp1));
                m_last = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [59:0] rnd_pp();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        if ($urandom_range(0, 7) == 0) t = '1;
        return t[59:0];
    endfunction

    bit acc0, acc1;

    initial begin
        rst_n          = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_pp    = '0;
        bus.req1_pp    = '0;
        bus.res_ready  = 1'b0;

        // reset state
        step();
        step();
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_occ", bus.occupancy, 0);
        chk("rst_sum", bus.res_sum, 0);
        chk("rst_ovf", bus.res_ovf, 0);
        chk("rst_id", bus.res_id, 0);
        // ready follows valid in reset, but nothing is taken
        bus.req0_valid = 1'b1;
        #1;
        chk("rst_ready0_comb", bus.req0_ready, 1);
        step();
        chk("rst_no_xfer", bus.occupancy, 0);
        bus.req0_valid = 1'b0;
        rst_n = 1'b1;
        step();

        // single request
        bus.req0_pp    = {15'd4, 15'd3, 15'd2, 15'd1};
        bus.req0_valid = 1'b1;
        bus.res_ready  = 1'b1;
        #1;
        chk("t1_ready0", bus.req0_ready, 1);
        step();
        bus.req0_valid = 1'b0;
        #1;
        chk("t1_not_yet", bus.res_valid, 0);
        chk("t1_occ1", bus.occupancy, 1);
        step();
        chk("t1_valid", bus.res_valid, 1);
        chk("t1_sum", bus.res_sum, 16'h000A);
        chk("t1_ovf", bus.res_ovf, 0);
        chk("t1_id", bus.res_id, 0);
        step();
        chk("t1_one_cycle", bus.res_valid, 0);
        chk("t1_occ0", bus.occupancy, 0);

        // overflow
        bus.req1_pp    = {4{15'h7FFF}};
        bus.req1_valid = 1'b1;
        #1;
        chk("t2_ready1", bus.req1_ready, 1);
        step();
        bus.req1_valid = 1'b0;
        step();
        chk("t2_sum", bus.res_sum, 16'hFFFC);
        chk("t2_ovf", bus.res_ovf, 1);
        chk("t2_id", bus.res_id, 1);
        bus.req1_pp    = {15'h0001, 15'h0001, 15'h7FFF, 15'h7FFF};
        bus.req1_valid = 1'b1;
        step();
        bus.req1_valid = 1'b0;
        step();
        chk("t2b_valid", bus.res_valid, 1);
        chk("t2b_sum", bus.res_sum, 16'h0000);
        chk("t2b_ovf", bus.res_ovf, 1);
        step();

        // fairness
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.req0_pp = {15'(4*i+4), 15'(4*i+3),
                           15'(4*i+2), 15'(4*i+1)};
            bus.req1_pp = {15'(4*i+104), 15'(4*i+103),
                           15'(4*i+102), 15'(4*i+101)};
            #1;
            chk("t3_grant", bus.req1_ready, i % 2);
            chk("t3_onehot", bus.req0_ready ^ bus.req1_ready, 1);
            if (i >= 2) begin
                chk("t3_rate", bus.res_valid, 1);
                chk("t3_res_id", bus.res_id, (i - 2) % 2);
            end
            step();
        end
        bus.req0_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.req1_pp = {15'(i+9), 15'(i+7), 15'(i+5), 15'(i+3)};
            #1;
            chk("t3_only1", bus.req1_ready, 1);
            step();
        end
        bus.req1_valid = 1'b0;
        step();
        step();
        step();

        // backpressure
        bus.req0_pp    = {15'd40, 15'd30, 15'd20, 15'd10};
        bus.req1_pp    = {15'd4000, 15'd3000, 15'd2000, 15'd1000};
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.res_ready  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (i >= 2) begin
                chk("t4_occ", bus.occupancy, 2);
                chk("t4_rdy0", bus.req0_ready, 0);
                chk("t4_rdy1", bus.req1_ready, 0);
                chk("t4_hold_sum", bus.res_sum, 100);
                chk("t4_hold_id", bus.res_id, 0);
            end
            step();
        end
        bus.res_ready = 1'b1;
        #1;
        chk("t4_resume", bus.req0_ready, 1);
        step();
        chk("t4_d1_id", bus.res_id, 1);
        chk("t4_d1_sum", bus.res_sum, 10000);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        step();
        chk("t4_d2_id", bus.res_id, 0);
        chk("t4_d2_sum", bus.res_sum, 100);
        step();
        chk("t4_empty", bus.res_valid, 0);

        // reset mid-operation
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.res_ready  = 1'b0;
        step();
        step();
        step();
        chk("t5_full", bus.occupancy, 2);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", bus.res_valid, 0);
        chk("t5_async_occ", bus.occupancy, 0);
        step();
        step();
        rst_n = 1'b1;
        bus.res_ready = 1'b1;
        #1;
        chk("t5_first_r0", bus.req0_ready, 1);
        chk("t5_first_r1", bus.req1_ready, 0);
        chk("t5_no_stale", bus.res_valid, 0);
        step();
        chk("t5_no_stale2", bus.res_valid, 0);
        step();
        chk("t5_first_res", bus.res_id, 0);
        chk("t5_first_sum", bus.res_sum, 100);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        step();
        step();
        step();

        // random
        acc0 = 1'b0;
        acc1 = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (!(bus.req0_valid && !acc0)) begin
                bus.req0_valid = ($urandom_range(0, 2) != 0);
                bus.req0_pp    = rnd_pp();
            end
            if (!(bus.req1_valid && !acc1)) begin
                bus.req1_valid = ($urandom_range(0, 2) != 0);
                bus.req1_pp    = rnd_pp();
            end
            bus.res_ready = ($urandom_range(0, 9) < 7);
            #1;
            acc0 = bus.req0_valid && bus.req0_ready;
            acc1 = bus.req1_valid && bus.req1_ready;
            step();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.res_ready  = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("final_drained", bus.occupancy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
